shift_unit_seq: RTL
===================

Name: shift_unit_seq

Overview:
Sequential, parametrised successor to the combinational shift operation in the ALU datapath.
- Performs logical, arithmetic and rotate shifts one bit position per clock.
- Uses a valid/ready handshake on both sides and reports carry-out and zero flags.
- Sits between the UART command decoder and the result serializer, so wide operands never create a long combinational path.

Parameters:
N, 16, operand width in bits; power of two, at least 4.
SW, $clog2(N), shift-amount width; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  request valid.
in_ready  output  1  unit can accept a request; high only in IDLE.
data_in  input  N  operand, signed.
shamt  input  SW  shift amount, 0..N-1.
mode  input  3  0 LSL, 1 LSR, 2 ASR, 3 ROL, 4 ROR, 5-7 reserved.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
data_out  output  N  result, signed.
carry_out  output  1  last bit shifted or rotated out.
zero  output  1  data_out == 0.
busy  output  1  state is not IDLE.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst. All state is registered.
- Reset values:
  - state = IDLE.
  - data_out, carry_out, out_valid, busy = 0.
  - zero = 1, because data_out = 0.
  - in_ready = 0 while rst is high, and 1 from the first cycle after rst is released.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid is high at an edge, latch data_in into the working register, shamt into the counter, and mode; clear carry.
  - Next state is SHIFT if shamt != 0, otherwise DONE.
- SHIFT: each cycle performs one single-bit step on the working register, records carry, and decrements the counter.
  - LSL: carry = bit N-1; shift in 0 at LSB.
  - LSR: carry = bit 0; shift in 0 at MSB.
  - ASR: carry = bit 0; replicate MSB.
  - ROL: carry = bit N-1, which also wraps into the LSB.
  - ROR: carry = bit 0, which also wraps into the MSB.
  - When the counter reaches 0 after a step, go to DONE.
- DONE:
  - out_valid = 1; data_out and carry_out are stable.
  - Hold until out_ready is high at an edge, then go to IDLE. out_valid drops the same edge.
- Latency: with a request accepted at edge T, out_valid is high in the cycle following edge T+shamt.
  - shamt = 0 gives out_valid one cycle after acceptance, with data_out = data_in and carry = 0.
- Throughput: one operation in flight. The minimum op-to-op spacing is shamt+2 cycles, including the out handshake.
- in_valid outside IDLE is ignored. Inputs are sampled only on the acceptance edge; later changes have no effect.
- Reserved modes 5-7 behave as shamt = 0: pass-through, carry 0.
- zero and data_out update together; zero is derived from the registered result.
- rst high in any state, including mid-SHIFT or DONE with out_ready low:
  - Next cycle is IDLE with reset values.
  - The partial result is discarded and no out_valid is produced.
- out_ready while not in DONE has no effect.

Optional Feature:
Macro SHIFT_FAST_EN.
- Defined: in SHIFT, when the counter is at least 4, the unit performs a 4-bit step per cycle and subtracts 4; otherwise it performs a 1-bit step.
  - carry = the last bit leaving in that step (bit N-4 for LSL/ROL, bit 3 for LSR/ASR/ROR).
  - Shift cycles = floor(shamt/4) + (shamt mod 4).
  - Results and flags are identical to the non-fast build.
- Undefined: 1 bit per cycle only. Latency is exactly as stated above.

Test Plan:
- Basic LSL (N=16): data_in 0x8001, shamt 1, mode LSL, out_ready = 1.
  - Expect data_out 0x0002, carry 1, zero 0.
  - out_valid 2 cycles after acceptance (non-fast), held exactly one cycle.
- Full-range ASR: data_in 0x8000, shamt 15, mode ASR.
  - Expect data_out 0xFFFF, carry 0.
  - Non-fast: out_valid 16 cycles after acceptance; busy high throughout.
  - SHIFT_FAST_EN: 6 shift cycles.
- Rotate: data_in 0xF000, shamt 4, mode ROL.
  - Expect 0x000F, carry 1.
  - Same operand, mode ROR, shamt 4: expect 0x0F00, carry 0.
- LSR zero and pass-through cases:
  - data_in 0x0001, shamt 1: expect data_out 0x0000, zero 1, carry 1.
  - data_in 0x00F0, shamt 0: expect 0x00F0, carry 0, out_valid in the cycle after acceptance.
  - Mode 6 with data_in 0x1234, shamt 7: expect 0x1234, carry 0.
- Backpressure: hold out_ready low for 5 cycles in DONE while pulsing in_valid with new data.
  - data_out, carry_out and out_valid stay stable; in_ready stays 0; the new request is not accepted.
  - When out_ready rises, the unit returns to IDLE and the next request is accepted.
- Reset mid-operation: assert rst for 1 cycle during SHIFT with shamt 10.
  - Next cycle: IDLE, out_valid 0, data_out 0x0000, zero 1.
  - No result is emitted afterwards; the next request completes normally.

Source files
------------

// File: rtl/shift_unit_seq_if.sv
// Request/response bundle for shift_unit_seq: operand side (in_*) and result side (out_*).
// The master drives requests and out_ready; the slave is the shift unit itself.
interface shift_unit_seq_if #(
    parameter int N = 16
);
    localparam int SW = $clog2(N);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  data_in;
    logic [SW-1:0] shamt;
    logic [2:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  data_out;
    logic          carry_out;
    logic          zero;
    logic          busy;

    modport master (
        output in_valid,
        output data_in,
        output shamt,
        output mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  data_out,
        input  carry_out,
        input  zero,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  data_in,
        input  shamt,
        input  mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output data_out,
        output carry_out,
        output zero,
        output busy
    );
endinterface

// File: rtl/shift_unit_seq.sv
// Multi-cycle LSL/LSR/ASR/ROL/ROR unit, one position per clock, valid/ready on both sides.
// Optional macro SHIFT_FAST_EN: take 4-position steps while at least 4 positions remain.
module shift_unit_seq #(
    parameter int N = 16
) (
    input logic             clk,
    input logic             rst,
    shift_unit_seq_if.slave bus
);
    localparam int SW = $clog2(N);

    localparam logic [2:0] MODE_LSL = 3'd0;
    localparam logic [2:0] MODE_LSR = 3'd1;
    localparam logic [2:0] MODE_ASR = 3'd2;
    localparam logic [2:0] MODE_ROL = 3'd3;
    localparam logic [2:0] MODE_ROR = 3'd4;

    localparam logic [SW-1:0] CNT_ONE  = SW'(1'b1);
    localparam logic [SW-1:0] CNT_ZERO = {SW{1'b0}};
    localparam logic [N-1:0]  WORD_ZERO = {N{1'b0}};

`ifdef SHIFT_FAST_EN
    // Threshold is one bit wider than the counter so that N=4 (2-bit counter) never takes a wide step.
    localparam logic [SW:0]   CNT_FOUR_WIDE = (SW+1)'(3'd4);
    localparam logic [SW-1:0] CNT_FOUR      = SW'(3'd4);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Single-position step; returns {carry, value}. Reserved modes pass through with carry 0.
    function automatic logic [N:0] step1(input logic [2:0] m, input logic [N-1:0] v);
        logic [N:0] r;
        case (m)
            MODE_LSL: r = {v[N-1], v[N-2:0], 1'b0};
            MODE_LSR: r = {v[0], 1'b0, v[N-1:1]};
            MODE_ASR: r = {v[0], v[N-1], v[N-1:1]};
            MODE_ROL: r = {v[N-1], v[N-2:0], v[N-1]};
            MODE_ROR: r = {v[0], v[0], v[N-1:1]};
            default:  r = {1'b0, v};
        endcase
        return r;
    endfunction

`ifdef SHIFT_FAST_EN
    // Four-position step; carry is the last bit to leave the word in that step.
    function automatic logic [N:0] step4(input logic [2:0] m, input logic [N-1:0] v);
        logic [N:0] r;
        case (m)
            MODE_LSL: r = {v[N-4], v << 3'd4};
            MODE_LSR: r = {v[3], v >> 3'd4};
            MODE_ASR: r = {v[3], $unsigned($signed(v) >>> 3'd4)};
            MODE_ROL: r = {v[N-4], (v << 3'd4) | (v >> (N-4))};
            MODE_ROR: r = {v[3], (v >> 3'd4) | (v << (N-4))};
            default:  r = {1'b0, v};
        endcase
        return r;
    endfunction
`endif

    function automatic logic is_zero(input logic [N-1:0] v);
        return (v == WORD_ZERO);
    endfunction

    state_e        state_r;
    state_e        state_next_s;
    logic [N-1:0]  work_r;
    logic [N-1:0]  work_next_s;
    logic [SW-1:0] count_r;
    logic [SW-1:0] count_next_s;
    logic [2:0]    mode_r;
    logic [2:0]    mode_next_s;
    logic          carry_r;
    logic          carry_next_s;
    logic          passthru_s;
    logic [N:0]    step_s;
    logic [SW-1:0] step_amt_s;
    logic          load_s;
    logic [N-1:0]  result_s;
    logic          result_carry_s;

    logic [N-1:0]  data_out_r;
    logic          carry_out_r;
    logic          zero_r;
    logic          out_valid_r;
    logic          in_ready_r;
    logic          busy_r;

    // Next-state logic and datapath step selection.
    always_comb begin
        state_next_s   = state_r;
        work_next_s    = work_r;
        count_next_s   = count_r;
        mode_next_s    = mode_r;
        carry_next_s   = carry_r;
        passthru_s     = 1'b0;
        step_s         = {carry_r, work_r};
        step_amt_s     = CNT_ONE;
        load_s         = 1'b0;
        result_s       = work_r;
        result_carry_s = carry_r;

        case (state_r)
            ST_IDLE: begin
                // in_ready_r is low for the first cycle after reset, so nothing is accepted then.
                if (in_ready_r && bus.in_valid) begin
                    passthru_s   = (bus.shamt == CNT_ZERO) || (bus.mode > MODE_ROR);
                    work_next_s  = bus.data_in;
                    count_next_s = bus.shamt;
                    mode_next_s  = bus.mode;
                    carry_next_s = 1'b0;
                    if (passthru_s) begin
                        state_next_s   = ST_DONE;
                        load_s         = 1'b1;
                        result_s       = bus.data_in;
                        result_carry_s = 1'b0;
                    end else begin
                        state_next_s = ST_SHIFT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end

            ST_SHIFT: begin
`ifdef SHIFT_FAST_EN
                if ({1'b0, count_r} >= CNT_FOUR_WIDE) begin
                    step_s     = step4(mode_r, work_r);
                    step_amt_s = CNT_FOUR;
                end else begin
                    step_s     = step1(mode_r, work_r);
                    step_amt_s = CNT_ONE;
                end
`else
                step_s     = step1(mode_r, work_r);
                step_amt_s = CNT_ONE;
`endif
                work_next_s  = step_s[N-1:0];
                carry_next_s = step_s[N];
                count_next_s = count_r - step_amt_s;
                if (count_next_s == CNT_ZERO) begin
                    state_next_s   = ST_DONE;
                    load_s         = 1'b1;
                    result_s       = step_s[N-1:0];
                    result_carry_s = step_s[N];
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end

            ST_DONE: begin
                if (bus.out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end

            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Working operand, remaining count, latched mode and running carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_r  <= WORD_ZERO;
            count_r <= CNT_ZERO;
            mode_r  <= 3'd0;
            carry_r <= 1'b0;
        end else begin
            work_r  <= work_next_s;
            count_r <= count_next_s;
            mode_r  <= mode_next_s;
            carry_r <= carry_next_s;
        end
    end

    // Registered outputs; handshake flags follow the next state so they line up with state_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r  <= WORD_ZERO;
            carry_out_r <= 1'b0;
            zero_r      <= 1'b1;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            out_valid_r <= (state_next_s == ST_DONE);
            in_ready_r  <= (state_next_s == ST_IDLE);
            busy_r      <= (state_next_s != ST_IDLE);
            if (load_s) begin
                data_out_r  <= result_s;
                carry_out_r <= result_carry_s;
                zero_r      <= is_zero(result_s);
            end else begin
                data_out_r  <= data_out_r;
                carry_out_r <= carry_out_r;
                zero_r      <= zero_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.data_out  = data_out_r;
    assign bus.carry_out = carry_out_r;
    assign bus.zero      = zero_r;
    assign bus.busy      = busy_r;

endmodule
